dds_voice_sched: RTL and testbench

Round-robin scheduler that time-shares one phase-accumulate / waveform datapath between `VOICES` DDS voices. It holds each voice's tuning word, gate and phase register, and advances one voice per clock. It presents the updated phase to the shared waveform stage (saw/other shapers) with a voice tag, and pulses a frame strobe once every voice has been serviced. Tuning-word and gate writes from the host/config logic enter through a one-entry valid/ready buffer. The buffer never races the slot being updated.

---
 rtl/dds_voice_sched_pkg.sv | 21 ++
 rtl/dds_voice_sched_voice_regfile.sv | 53 +++++
 rtl/dds_voice_sched.sv | 133 +++++++++++++
 tb/tb_dds_voice_sched.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_voice_sched_pkg.sv
// Shared types for the DDS voice scheduler: scheduler state and the config write record
// (the record is also used by the host-interface block).
package dds_voice_sched_pkg;

  localparam int DDS_N      = 14;
  localparam int DDS_VOICES = 4;
  localparam int DDS_VW     = $clog2(DDS_VOICES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [DDS_VW-1:0] voice;
    logic [DDS_N-1:0]  ftw;
    logic              gate;
    logic              clr;
  } cfg_rec_t;

endpackage

// File: rtl/dds_voice_sched_voice_regfile.sv
// Per-voice tuning word, gate and phase storage with one accumulate port and one config
// write port; the scheduler guarantees the two never target the same voice in a cycle.
module dds_voice_sched_voice_regfile
  import dds_voice_sched_pkg::*;
#(
  parameter  int N      = DDS_N,
  parameter  int VOICES = DDS_VOICES,
  localparam int VW     = $clog2(VOICES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_en_i,
  input  logic [VW-1:0] acc_slot_i,
  output logic          acc_gate_o,
  output logic [N-1:0]  acc_phase_o,
  input  logic          wr_en_i,
  input  cfg_rec_t      wr_rec_i
);

  logic [N-1:0]      ftw_q   [VOICES];
  logic [N-1:0]      phase_q [VOICES];
  logic [VOICES-1:0] gate_q;

  // Phase is an unsigned modulo-2^N accumulator: the carry out is simply dropped.
  function automatic logic [N-1:0] phase_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return a + b;
  endfunction

  assign acc_gate_o  = gate_q[acc_slot_i];
  assign acc_phase_o = phase_add(phase_q[acc_slot_i], ftw_q[acc_slot_i]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        ftw_q[i]   <= '0;
        phase_q[i] <= '0;
      end
      gate_q <= '0;
    end else begin
      if (acc_en_i && gate_q[acc_slot_i]) begin
        phase_q[acc_slot_i] <= acc_phase_o;
      end
      if (wr_en_i) begin
        ftw_q[wr_rec_i.voice]  <= wr_rec_i.ftw;
        gate_q[wr_rec_i.voice] <= wr_rec_i.gate;
        if (wr_rec_i.clr) begin
          phase_q[wr_rec_i.voice] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/dds_voice_sched.sv
// Round-robin scheduler sharing one phase accumulator across VOICES DDS voices, with a
// one-entry config buffer that waits whenever its target voice is the one being serviced.
module dds_voice_sched
  import dds_voice_sched_pkg::*;
#(
  parameter  int N      = DDS_N,
  parameter  int VOICES = DDS_VOICES,
  localparam int VW     = $clog2(VOICES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [VW-1:0] cfg_voice,
  input  logic [N-1:0]  cfg_ftw,
  input  logic          cfg_gate,
  input  logic          cfg_clr,
  output logic [N-1:0]  phase_out,
  output logic [VW-1:0] phase_voice,
  output logic          phase_valid,
  output logic          frame_strobe
);

  localparam logic [VW-1:0] LAST_SLOT = VW'(VOICES - 1);

  sched_state_e  state_q;
  logic [VW-1:0] slot_q;
  logic [N-1:0]  phase_out_q;
  logic [VW-1:0] phase_voice_q;
  logic          phase_valid_q;
  logic          frame_strobe_q;

  cfg_rec_t      buf_q, buf_d;
  logic          buf_full_q, buf_full_d;

  logic          servicing;
  logic          cfg_accept;
  logic          cfg_apply;
  logic          acc_gate;
  logic [N-1:0]  acc_phase;

  assign servicing  = (state_q == ST_RUN);
  assign cfg_accept = cfg_valid && !buf_full_q;
  // Holding the write while its voice is in the accumulator removes any same-cycle conflict.
  assign cfg_apply  = buf_full_q && (!servicing || (slot_q != buf_q.voice));

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (cfg_apply) begin
      buf_full_d = 1'b0;
    end
    if (cfg_accept) begin
      buf_d.voice = cfg_voice;
      buf_d.ftw   = cfg_ftw;
      buf_d.gate  = cfg_gate;
      buf_d.clr   = cfg_clr;
      buf_full_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      phase_out_q    <= '0;
      phase_voice_q  <= '0;
      phase_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
    end else begin
      phase_valid_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          slot_q <= '0;
          if (run) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          phase_voice_q <= slot_q;
          phase_valid_q <= acc_gate;
          if (acc_gate) begin
            phase_out_q <= acc_phase;
          end
          // run is only sampled at the frame boundary so a frame is never cut short.
          if (slot_q == LAST_SLOT) begin
            frame_strobe_q <= 1'b1;
            slot_q         <= '0;
            if (!run) begin
              state_q <= ST_IDLE;
            end
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dds_voice_sched_voice_regfile #(
    .N      (N),
    .VOICES (VOICES)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .acc_en_i    (servicing),
    .acc_slot_i  (slot_q),
    .acc_gate_o  (acc_gate),
    .acc_phase_o (acc_phase),
    .wr_en_i     (cfg_apply),
    .wr_rec_i    (buf_q)
  );

  assign cfg_ready    = !buf_full_q;
  assign phase_out    = phase_out_q;
  assign phase_voice  = phase_voice_q;
  assign phase_valid  = phase_valid_q;
  assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_dds_voice_sched.sv
// Bench for dds_voice_sched: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of voices, frame schedule and the config buffer.
module tb_dds_voice_sched;

  localparam int N      = 14;
  localparam int VOICES = 4;
  localparam int VW     = 2;
  localparam int MOD    = 1 << N;
  localparam int OW     = N + VW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [N-1:0]  cfg_ftw = '0;
  logic          cfg_gate = 1'b0;
  logic          cfg_clr = 1'b0;
  logic          cfg_ready;
  logic [N-1:0]  phase_out;
  logic [VW-1:0] phase_voice;
  logic          phase_valid;
  logic          frame_strobe;

  dds_voice_sched #(.N(N), .VOICES(VOICES)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_voice    (cfg_voice),
    .cfg_ftw      (cfg_ftw),
    .cfg_gate     (cfg_gate),
    .cfg_clr      (cfg_clr),
    .phase_out    (phase_out),
    .phase_voice  (phase_voice),
    .phase_valid  (phase_valid),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_phase [VOICES];
  int m_ftw   [VOICES];
  bit m_gate  [VOICES];
  bit m_running;
  int m_slot;
  bit m_full;
  int m_bv, m_bftw;
  bit m_bgate, m_bclr;
  int e_phase, e_voice;
  bit e_valid, e_strobe;

  function automatic logic [OW-1:0] dut_vec();
    return {phase_out, phase_voice, phase_valid, frame_strobe, cfg_ready};
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    return {N'(e_phase), VW'(e_voice), e_valid, e_strobe, ~m_full};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_phase[i] = 0; m_ftw[i] = 0; m_gate[i] = 0;
    end
    m_running = 0; m_slot = 0; m_full = 0;
    m_bv = 0; m_bftw = 0; m_bgate = 0; m_bclr = 0;
    e_phase = 0; e_voice = 0; e_valid = 0; e_strobe = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit apply, accept;
    int k;
    k = m_slot;
    apply  = m_full && (!m_running || k != m_bv);
    accept = (cfg_valid === 1'b1) && !m_full;
    e_valid = 0;
    e_strobe = 0;
    if (m_running) begin
      e_voice = k;
      if (m_gate[k]) begin
        m_phase[k] = (m_phase[k] + m_ftw[k]) % MOD;
        e_phase = m_phase[k];
        e_valid = 1;
      end
      if (k == VOICES - 1) begin
        e_strobe = 1;
        m_slot = 0;
        m_running = (run === 1'b1);
      end else begin
        m_slot = k + 1;
      end
    end else if (run === 1'b1) begin
      m_running = 1;
    end
    if (apply) begin
      m_ftw[m_bv] = m_bftw;
      m_gate[m_bv] = m_bgate;
      if (m_bclr) m_phase[m_bv] = 0;
      m_full = 0;
    end
    if (accept) begin
      m_bv = int'(cfg_voice); m_bftw = int'(cfg_ftw);
      m_bgate = cfg_gate; m_bclr = cfg_clr;
      m_full = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 0; cfg_valid = 0; rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic cfg_write(input int v, input int f, input bit g, input bit c);
    for (int guard = 0; guard < 50 && m_full; guard++) tick();
    cfg_valid = 1; cfg_voice = VW'(v); cfg_ftw = N'(f); cfg_gate = g; cfg_clr = c;
    tick();
    cfg_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== OW'(1)) begin
      errors++; $display("FAIL reset_initial got=%h exp=%h", dut_vec(), OW'(1));
    end
    run = 1;
    cfg_write(1, 'h100, 1, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_prerun got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    cfg_valid = 1; cfg_voice = 0; cfg_ftw = 'h5; cfg_gate = 1; cfg_clr = 0;
    tick();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL reset_buffer_full got=%b exp=0", cfg_ready);
    end
    #3 rst = 1;
    #1;
    checks++;
    if (dut_vec() !== OW'(1)) begin
      errors++; $display("FAIL reset_async got=%h exp=%h", dut_vec(), OW'(1));
    end
    model_reset();
    run = 0;
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (phase_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    run = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_lost_write got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int hits, last_c;
    do_reset();
    cfg_write(1, 'h100, 1, 0);
    tick();
    run = 1;
    hits = 0; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL basic_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (phase_valid === 1'b1 && phase_voice === 2'd1) begin
        hits++;
        checks++;
        if (phase_out !== N'(hits * 'h100)) begin
          errors++; $display("FAIL basic_phase got=%h exp=%h", phase_out, N'(hits * 'h100));
        end
        if (last_c >= 0) begin
          checks++;
          if (c - last_c != VOICES) begin
            errors++; $display("FAIL basic_spacing got=%0d exp=%0d", c - last_c, VOICES);
          end
        end
        last_c = c;
      end
      checks++;
      if (frame_strobe !== (phase_voice == 2'd3)) begin
        errors++; $display("FAIL basic_strobe got=%b voice=%0d", frame_strobe, phase_voice);
      end
    end
    checks++;
    if (hits < 3) begin
      errors++; $display("FAIL basic_hits got=%0d exp>=3", hits);
    end
  endtask

  task automatic test_wrap();
    int idx;
    int exp_seq [4];
    exp_seq = '{'h3FFF, 'h3FFE, 'h3FFD, 'h3FFC};
    do_reset();
    cfg_write(0, 'h123, 1, 0);
    run = 1;
    for (int i = 0; i < 10; i++) tick();
    for (int g = 0; g < 20 && !(m_running && m_slot == 1); g++) tick();
    cfg_write(0, 'h3FFF, 1, 1);
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL wrap_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (phase_valid === 1'b1 && phase_voice === 2'd0 && idx < 4) begin
        checks++;
        if (phase_out !== N'(exp_seq[idx])) begin
          errors++; $display("FAIL wrap_phase got=%h exp=%h", phase_out, N'(exp_seq[idx]));
        end
        idx++;
      end
    end
    checks++;
    if (idx < 3) begin
      errors++; $display("FAIL wrap_count got=%0d exp>=3", idx);
    end
  endtask

  task automatic test_collision();
    int base;
    bit found;
    do_reset();
    cfg_write(2, 'h5, 1, 0);
    run = 1;
    for (int i = 0; i < 9; i++) tick();
    for (int g = 0; g < 20 && !(m_running && m_slot == 1); g++) tick();
    base = m_phase[2];
    cfg_valid = 1; cfg_voice = 2; cfg_ftw = 'h10; cfg_gate = 1; cfg_clr = 0;
    tick();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL coll_ready1 got=%b exp=0", cfg_ready);
    end
    tick();
    checks++;
    if (cfg_ready !== 1'b0 || phase_voice !== 2'd2 || phase_out !== N'((base + 'h5) % MOD)) begin
      errors++; $display("FAIL coll_old_ftw got=%b/%0d/%h exp=0/2/%h",
                         cfg_ready, phase_voice, phase_out, N'((base + 'h5) % MOD));
    end
    tick();
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL coll_ready3 got=%b exp=1", cfg_ready);
    end
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL coll_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (phase_valid === 1'b1 && phase_voice === 2'd2) begin
        found = 1;
        checks++;
        if (phase_out !== N'((base + 'h15) % MOD)) begin
          errors++; $display("FAIL coll_new_ftw got=%h exp=%h", phase_out, N'((base + 'h15) % MOD));
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL coll_timeout got=none exp=voice2");
    end
  endtask

  task automatic test_stop();
    int strobes;
    bit seen2, seen3;
    logic [N-1:0] held;
    do_reset();
    cfg_write(1, 'h40, 1, 0);
    cfg_write(2, 'h80, 1, 0);
    cfg_write(3, 'h11, 1, 0);
    run = 1;
    for (int i = 0; i < 6; i++) tick();
    for (int g = 0; g < 20 && !(m_running && m_slot == 1); g++) tick();
    run = 0;
    strobes = 0; seen2 = 0; seen3 = 0; held = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stop_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (phase_valid === 1'b1 && phase_voice === 2'd2) seen2 = 1;
      if (phase_valid === 1'b1 && phase_voice === 2'd3) seen3 = 1;
      if (frame_strobe === 1'b1) begin
        strobes++;
        held = phase_out;
      end else if (strobes > 0) begin
        checks++;
        if (phase_valid !== 1'b0 || phase_out !== held) begin
          errors++; $display("FAIL stop_frozen got=%b/%h exp=0/%h", phase_valid, phase_out, held);
        end
      end
    end
    checks++;
    if (strobes != 1) begin
      errors++; $display("FAIL stop_strobes got=%0d exp=1", strobes);
    end
    checks++;
    if (!(seen2 && seen3)) begin
      errors++; $display("FAIL stop_frame_done got=%b%b exp=11", seen2, seen3);
    end
    run = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stop_resume got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_gate_off();
    int last_v3, off_hits;
    bit found;
    logic [N-1:0] prev_out;
    do_reset();
    cfg_write(3, 'h77, 1, 0);
    cfg_write(2, 'h5, 1, 0);
    run = 1;
    last_v3 = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (phase_valid === 1'b1 && phase_voice === 2'd3) last_v3 = int'(phase_out);
    end
    prev_out = phase_out;
    off_hits = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin
        cfg_valid = 1; cfg_voice = 3; cfg_ftw = 'h77; cfg_gate = 0; cfg_clr = 0;
      end
      tick();
      cfg_valid = 0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL gate_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (phase_voice === 2'd3 && phase_valid === 1'b1) begin
        checks++;
        if (off_hits > 0) begin
          errors++; $display("FAIL gate_valid_after_off got=1 exp=0");
        end
        last_v3 = int'(phase_out);
      end else if (phase_voice === 2'd3) begin
        off_hits++;
        checks++;
        if (frame_strobe !== 1'b1 || phase_out !== prev_out) begin
          errors++; $display("FAIL gate_off_slot got=%b/%h exp=1/%h", frame_strobe, phase_out, prev_out);
        end
      end
      prev_out = phase_out;
    end
    checks++;
    if (off_hits < 2) begin
      errors++; $display("FAIL gate_off_hits got=%0d exp>=2", off_hits);
    end
    found = 0;
    for (int c = 0; c < 14 && !found; c++) begin
      if (c == 0) begin
        cfg_valid = 1; cfg_voice = 3; cfg_ftw = 'h100; cfg_gate = 1; cfg_clr = 0;
      end
      tick();
      cfg_valid = 0;
      if (phase_valid === 1'b1 && phase_voice === 2'd3) begin
        found = 1;
        checks++;
        if (phase_out !== N'((last_v3 + 'h100) % MOD)) begin
          errors++; $display("FAIL gate_frozen_phase got=%h exp=%h", phase_out, N'((last_v3 + 'h100) % MOD));
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL gate_regate_timeout got=none exp=voice3");
    end
  endtask

  task automatic test_random();
    do_reset();
    run = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_voice = VW'($urandom_range(0, VOICES - 1));
      cfg_ftw   = N'($urandom);
      cfg_gate  = ($urandom_range(0, 4) != 0);
      cfg_clr   = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_c%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      end
    end
    cfg_valid = 0;
    run = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_collision();
    test_stop();
    test_gate_off();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
